rv32_regfile_alu_dec: RTL and testbench

Combined single-cycle RV32 execution primitives for the npc core: a 32x32-bit register file, an integer ALU and a 3-to-8 one-hot funct3 decoder. Used by the core datapath as follows:
- register file feeds src1/src2 and accepts the final writeback value;
- ALU computes add-class results and load/store addresses;
- decoder produces funct3 one-hot terms for instruction recognition.
All three sections are independent apart from the shared clock and reset.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/rv_alu.sv | 35 +++
 rtl/rv32_regfile_alu_dec.sv | 51 +++++
 tb/tb_rv32_regfile_alu_dec.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the npc core execution primitives: data widths,
// one-hot ALU op bit positions and the funct3 encodings the core decodes.
package rv_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int ALU_OPS = 10;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SW  = 3'd2;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32 integer ALU with a one-hot op select; the result is the
// OR of every selected operation, so zero ops selected yields zero.
module rv_alu
  import rv_pkg::*;
(
  input  logic [XLEN-1:0]    a_i,
  input  logic [XLEN-1:0]    b_i,
  input  logic [ALU_OPS-1:0] op_i,
  output logic [XLEN-1:0]    result_o
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] res [ALU_OPS];

  assign shamt = b_i[4:0];

  always_comb begin
    res[ALU_ADD]  = a_i + b_i;
    res[ALU_SUB]  = a_i - b_i;
    res[ALU_SLT]  = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
    res[ALU_SLTU] = {{(XLEN-1){1'b0}}, (a_i < b_i)};
    res[ALU_AND]  = a_i & b_i;
    res[ALU_OR]   = a_i | b_i;
    res[ALU_XOR]  = a_i ^ b_i;
    res[ALU_SLL]  = a_i << shamt;
    res[ALU_SRL]  = a_i >> shamt;
    res[ALU_SRA]  = $unsigned($signed(a_i) >>> shamt);

    result_o = '0;
    for (int i = 0; i < ALU_OPS; i++) begin
      result_o = result_o | ({XLEN{op_i[i]}} & res[i]);
    end
  end

endmodule

// File: rtl/rv32_regfile_alu_dec.sv
// npc execution primitives: 32x32 register file (async read, no bypass),
// integer ALU and funct3 one-hot decoder sharing only clock and reset.
module rv32_regfile_alu_dec
  import rv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wen,
  input  logic [4:0]         waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic [4:0]         raddr1,
  output logic [XLEN-1:0]    rdata1,
  input  logic [4:0]         raddr2,
  output logic [XLEN-1:0]    rdata2,
  input  logic [XLEN-1:0]    alu_src1,
  input  logic [XLEN-1:0]    alu_src2,
  input  logic [ALU_OPS-1:0] alu_op,
  output logic [XLEN-1:0]    alu_result,
  input  logic [2:0]         f3_in,
  output logic [7:0]         f3_onehot
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 is forced at the read mux so it stays zero regardless of array content
  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

  rv_alu u_alu (
    .a_i      (alu_src1),
    .b_i      (alu_src2),
    .op_i     (alu_op),
    .result_o (alu_result)
  );

  always_comb begin
    f3_onehot        = '0;
    f3_onehot[f3_in] = 1'b1;
  end

endmodule

// File: tb/tb_rv32_regfile_alu_dec.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops
// and compares them against the selected DUT output.
module tb_rv32_regfile_alu_dec;
  import rv_pkg::*;

  logic               clk;
  logic               reset;
  logic               wen;
  logic [4:0]         waddr;
  logic [XLEN-1:0]    wdata;
  logic [4:0]         raddr1;
  logic [XLEN-1:0]    rdata1;
  logic [4:0]         raddr2;
  logic [XLEN-1:0]    rdata2;
  logic [XLEN-1:0]    alu_src1;
  logic [XLEN-1:0]    alu_src2;
  logic [ALU_OPS-1:0] alu_op;
  logic [XLEN-1:0]    alu_result;
  logic [2:0]         f3_in;
  logic [7:0]         f3_onehot;

  rv32_regfile_alu_dec dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .f3_in      (f3_in),
    .f3_onehot  (f3_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // port: 0 rdata1, 1 rdata2, 2 alu_result, 3 f3_onehot
  typedef struct {
    int          port;
    logic [31:0] exp;
    string       name;
  } item_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [9:0]  op;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic expect_val(input int port, input logic [31:0] exp, input string name);
    item_t it;
    it.port = port;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    item_t       it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.port)
        0:       act = rdata1;
        1:       act = rdata2;
        2:       act = alu_result;
        default: act = {24'd0, f3_onehot};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
      end
    end
  end

  alu_vec_t alu_vecs[$];

  initial begin
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0010, 10'(1) << ALU_ADD,  32'h8000_0010, "add_basic"});
    alu_vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 10'(1) << ALU_ADD,  32'h0000_0000, "add_wrap"});
    alu_vecs.push_back('{32'h0000_0005, 32'hFFFF_FFFF, 10'(1) << ALU_ADD,  32'h0000_0004, "addi_neg"});
    alu_vecs.push_back('{32'h0000_0005, 32'h0000_0007, 10'd0,              32'h0000_0000, "op_zero"});
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0001, 10'(1) << ALU_SUB,  32'h7FFF_FFFF, "sub"});
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0001, 10'(1) << ALU_SLT,  32'h0000_0001, "slt"});
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0001, 10'(1) << ALU_SLTU, 32'h0000_0000, "sltu"});
    alu_vecs.push_back('{32'h0000_0001, 32'h8000_0000, 10'(1) << ALU_SLTU, 32'h0000_0001, "sltu_true"});
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0004, 10'(1) << ALU_SRA,  32'hF800_0000, "sra"});
    alu_vecs.push_back('{32'h8000_0000, 32'h0000_0004, 10'(1) << ALU_SRL,  32'h0800_0000, "srl"});
    alu_vecs.push_back('{32'h0000_0003, 32'h0000_0021, 10'(1) << ALU_SLL,  32'h0000_0006, "sll_b21"});
    alu_vecs.push_back('{32'h0000_00F0, 32'h0000_003C, (10'(1) << ALU_AND) | (10'(1) << ALU_OR), 32'h0000_00FC, "and_or"});
    alu_vecs.push_back('{32'h0000_00F0, 32'h0000_003C, 10'(1) << ALU_XOR,  32'h0000_00CC, "xor"});

    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd5; raddr2 = '0; alu_src1 = '0; alu_src2 = '0; alu_op = '0; f3_in = 3'd3;
    cyc();
    expect_val(0, 32'h0, "rst_x5");
    expect_val(3, 32'h08, "f3_during_reset");
    cyc();
    reset = 1'b0;

    // x5 cleared by a reset edge
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5;
    cyc();
    wen = 1'b0;
    expect_val(0, 32'hDEAD_BEEF, "x5_written");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_val(0, 32'h0, "x5_after_reset");
    cyc();

    // x0 ignores writes
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0; raddr2 = 5'd0;
    expect_val(0, 32'h0, "x0_pre_write");
    cyc();
    wen = 1'b0;
    expect_val(0, 32'h0, "x0_post_write");
    expect_val(1, 32'h0, "x0_port2");
    cyc();

    // read-during-write returns old value, new value after the edge
    wen = 1'b1; waddr = 5'd10; wdata = 32'h8000_0004; raddr1 = 5'd10;
    expect_val(0, 32'h0, "rdw_old");
    cyc();
    wen = 1'b0; wdata = 32'hCAFE_F00D;
    expect_val(0, 32'h8000_0004, "rdw_new");
    cyc();
    expect_val(0, 32'h8000_0004, "wen0_hold");
    cyc();

    // dual read
    wen = 1'b1; waddr = 5'd1; wdata = 32'h11;
    cyc();
    waddr = 5'd2; wdata = 32'h22;
    cyc();
    wen = 1'b0; raddr1 = 5'd1; raddr2 = 5'd2;
    expect_val(0, 32'h11, "dual_rd1");
    expect_val(1, 32'h22, "dual_rd2");
    cyc();
    raddr1 = 5'd2;
    expect_val(0, 32'h22, "same_rd1");
    expect_val(1, 32'h22, "same_rd2");
    cyc();

    foreach (alu_vecs[i]) begin
      alu_src1 = alu_vecs[i].a;
      alu_src2 = alu_vecs[i].b;
      alu_op   = alu_vecs[i].op;
      expect_val(2, alu_vecs[i].exp, alu_vecs[i].name);
      cyc();
    end

    for (int k = 0; k < 8; k++) begin
      f3_in = 3'(k);
      expect_val(3, 32'(8'h01 << k), $sformatf("f3_%0d", k));
      cyc();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
